cart_load_ctrl: RTL

- Sequences cartridge download from the HPS ioctl stream into the 32 KB cart ROM dual-port RAM write port.
- Tracks the loaded image size and decodes the file extension into a bank-switch scheme.
- Auto-detects SuperChip RAM by probing each 4K bank during the transfer.
- Holds the console core in reset until the new configuration (force_bs, sc, rom_size) is stable; sits between hps_io and the A2601 core.

---
 rtl/cart_pkg.sv | 44 ++++
 rtl/cart_ext_decode.sv | 56 +++++
 rtl/cart_load_ctrl.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/cart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cart_pkg
// Description : Shared constants, state encoding and size-to-scheme helper
//               for the cartridge load controller.
// Revision    : 1.0
// ============================================================================
package cart_pkg;

    localparam logic [3:0] BS_NONE = 4'd0;
    localparam logic [3:0] BS_F8   = 4'd1;
    localparam logic [3:0] BS_F6   = 4'd2;
    localparam logic [3:0] BS_FE   = 4'd3;
    localparam logic [3:0] BS_E0   = 4'd4;
    localparam logic [3:0] BS_3F   = 4'd5;
    localparam logic [3:0] BS_F4   = 4'd6;
    localparam logic [3:0] BS_P2   = 4'd7;
    localparam logic [3:0] BS_FA   = 4'd8;
    localparam logic [3:0] BS_CV   = 4'd9;

    localparam int ROM_MAX = 32768;
    localparam int BANK_W  = 12;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        SETTLE = 2'd2,
        RUN    = 2'd3
    } state_t;

    // Scheme implied by image size when the extension says nothing.
    function automatic logic [3:0] size_bs(input logic [16:0] size, input logic ext_s);
        case (size)
            17'd8192:  size_bs = BS_F8;
            17'd16384: size_bs = BS_F6;
            17'd32768: size_bs = BS_F4;
            17'd12288: size_bs = BS_FA;
            17'd2048:  size_bs = ext_s ? BS_NONE : BS_CV;
            default:   size_bs = BS_NONE;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/cart_ext_decode.sv
`default_nettype none
// ============================================================================
// Module      : cart_ext_decode
// Description : Registered decode of the download file extension into a
//               bank-switch scheme code and the SuperChip "S" suffix flag.
// Revision    : 1.0
// ============================================================================
module cart_ext_decode
    import cart_pkg::*;
(
    input  logic        clk_sys,
    input  logic        reset,
    input  logic [31:0] i_file_ext,
    output logic [3:0]  o_force_bs,
    output logic        o_ext_s
);

    logic [23:0] w_ext;
    logic [3:0]  w_code;
    logic [3:0]  r_force_bs;
    logic        r_ext_s;

    // Two-char extensions arrive right-aligned with the dot in byte 2.
    assign w_ext = (i_file_ext[23:16] == ".") ? i_file_ext[23:0] : i_file_ext[31:8];

    always_comb begin
        w_code = BS_NONE;
        case (w_ext)
            ".F8":   w_code = BS_F8;
            ".F6":   w_code = BS_F6;
            ".FE":   w_code = BS_FE;
            ".E0":   w_code = BS_E0;
            ".3F":   w_code = BS_3F;
            ".F4":   w_code = BS_F4;
            ".P2":   w_code = BS_P2;
            ".FA":   w_code = BS_FA;
            ".CV":   w_code = BS_CV;
            default: w_code = BS_NONE;
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_force_bs <= BS_NONE;
            r_ext_s    <= 1'b0;
        end else begin
            r_force_bs <= w_code;
            r_ext_s    <= (i_file_ext[7:0] == "S");
        end
    end

    assign o_force_bs = r_force_bs;
    assign o_ext_s    = r_ext_s;

endmodule
`default_nettype wire

// File: rtl/cart_load_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : cart_load_ctrl
// Description : Cartridge download sequencer between hps_io and the A2601
//               core: ROM write port, size tracking, bank-switch decode,
//               SuperChip probe and core reset hold. Optional macro
//               CART_SIZE_BS_EN picks a scheme from image size when the
//               extension is unknown.
// Revision    : 1.0
// ============================================================================
module cart_load_ctrl
    import cart_pkg::*;
#(
    parameter int ADDR_W     = 15,
    parameter int RESET_HOLD = 16,
    parameter int SC_PROBE   = 128
)(
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              ioctl_download,
    input  logic              ioctl_wr,
    input  logic [24:0]       ioctl_addr,
    input  logic [7:0]        ioctl_dout,
    input  logic [31:0]       ioctl_file_ext,
    input  logic [1:0]        sc_mode,
    output logic              rom_we,
    output logic [ADDR_W-1:0] rom_waddr,
    output logic [7:0]        rom_wdata,
    output logic [3:0]        force_bs,
    output logic              sc,
    output logic [16:0]       rom_size,
    output logic              oversize,
    output logic              core_reset,
    output logic              cfg_valid
);

    localparam int CNT_W = (RESET_HOLD > 1) ? $clog2(RESET_HOLD) : 1;

    state_t            r_state;
    logic              r_dl_q;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_latch_ext;
    logic              r_rom_we;
    logic [ADDR_W-1:0] r_rom_waddr;
    logic [7:0]        r_rom_wdata;
    logic [3:0]        r_force_bs;
    logic              r_ext_s;
    logic              r_sc;
    logic [16:0]       r_rom_size;
    logic              r_oversize;
    logic              r_core_reset;
    logic              r_cfg_valid;
    logic [7:0]        r_probe;
    logic [7:0]        r_cap [8];

    logic [3:0]        w_dec_bs;
    logic              w_dec_s;
    logic              w_rise;
    logic              w_fall;
    logic              w_wr;
    logic              w_in_rom;
    logic [2:0]        w_bank;
    logic [11:0]       w_off;
    logic [16:0]       w_addr_p1;
    logic [16:0]       w_size_base;
    logic              w_probe_ok;
    logic              w_sc_next;

    cart_ext_decode u_ext_decode (
        .clk_sys    (clk_sys),
        .reset      (reset),
        .i_file_ext (ioctl_file_ext),
        .o_force_bs (w_dec_bs),
        .o_ext_s    (w_dec_s)
    );

    assign w_rise      = ioctl_download & ~r_dl_q;
    assign w_fall      = ~ioctl_download & r_dl_q & (r_state == LOAD);
    assign w_wr        = ioctl_wr & (w_rise | (r_state == LOAD));
    assign w_in_rom    = ioctl_addr < 25'(ROM_MAX);
    assign w_bank      = ioctl_addr[14:12];
    assign w_off       = ioctl_addr[11:0];
    assign w_addr_p1   = {2'b00, ioctl_addr[14:0]} + 17'd1;
    // A write on the restart cycle must build on the cleared size, not the old one.
    assign w_size_base = w_rise ? 17'd0 : r_rom_size;

    always_comb begin
        w_probe_ok = 1'b1;
        for (int b = 0; b < 8; b++) begin
            if ((r_rom_size > (17'(b) << BANK_W)) && !r_probe[b]) w_probe_ok = 1'b0;
        end
        case (sc_mode)
            2'd0:    w_sc_next = (r_rom_size != 17'd0) &
                                 (r_ext_s | ((r_rom_size >= 17'd4096) & w_probe_ok));
            2'd1:    w_sc_next = 1'b0;
            default: w_sc_next = 1'b1;
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_state      <= IDLE;
            r_dl_q       <= 1'b0;
            r_cnt        <= '0;
            r_latch_ext  <= 1'b0;
            r_rom_we     <= 1'b0;
            r_rom_waddr  <= '0;
            r_rom_wdata  <= 8'd0;
            r_force_bs   <= BS_NONE;
            r_ext_s      <= 1'b0;
            r_sc         <= 1'b0;
            r_rom_size   <= 17'd0;
            r_oversize   <= 1'b0;
            r_core_reset <= 1'b1;
            r_cfg_valid  <= 1'b0;
            r_probe      <= 8'hFF;
        end else begin
            r_dl_q      <= ioctl_download;
            r_rom_we    <= 1'b0;
            r_latch_ext <= 1'b0;

            if (w_rise) begin
                r_state      <= LOAD;
                r_core_reset <= 1'b1;
                r_cfg_valid  <= 1'b0;
                r_rom_size   <= 17'd0;
                r_oversize   <= 1'b0;
                r_probe      <= 8'hFF;
                r_latch_ext  <= 1'b1;
            end else begin
                case (r_state)
                    LOAD: begin
                        if (w_fall) begin
                            r_state <= SETTLE;
                            r_cnt   <= CNT_W'(RESET_HOLD - 1);
                        end
                    end
                    SETTLE: begin
                        r_sc <= w_sc_next;
`ifdef CART_SIZE_BS_EN
                        if (r_force_bs == BS_NONE) r_force_bs <= size_bs(r_rom_size, r_ext_s);
`endif
                        if (r_cnt == '0) begin
                            r_state      <= RUN;
                            r_core_reset <= 1'b0;
                            r_cfg_valid  <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt - CNT_W'(1);
                        end
                    end
                    default: ;
                endcase
            end

            // Decoder output reflects the extension seen on the LOAD entry cycle.
            if (r_latch_ext) begin
                r_force_bs <= w_dec_bs;
                r_ext_s    <= w_dec_s;
            end

            if (w_wr) begin
                if (w_in_rom) begin
                    r_rom_we    <= 1'b1;
                    r_rom_waddr <= ioctl_addr[ADDR_W-1:0];
                    r_rom_wdata <= ioctl_dout;
                    r_rom_size  <= (w_addr_p1 > w_size_base) ? w_addr_p1 : w_size_base;
                    if (w_off == 12'd0) begin
                        r_cap[w_bank] <= ioctl_dout;
                    end else if ((w_off < 12'(SC_PROBE)) && (ioctl_dout != r_cap[w_bank])) begin
                        r_probe[w_bank] <= 1'b0;
                    end
                end else begin
                    r_oversize <= 1'b1;
                    r_rom_size <= 17'(ROM_MAX);
                end
            end
        end
    end

    assign rom_we     = r_rom_we;
    assign rom_waddr  = r_rom_waddr;
    assign rom_wdata  = r_rom_wdata;
    assign force_bs   = r_force_bs;
    assign sc         = r_sc;
    assign rom_size   = r_rom_size;
    assign oversize   = r_oversize;
    assign core_reset = r_core_reset;
    assign cfg_valid  = r_cfg_valid;

endmodule
`default_nettype wire
